// File: rtl/irq_controller_if.sv
// CPU-side register bus of the interrupt controller: 16-byte window,
// byte write strobes and combinational read data.
interface irq_controller_if;
    logic        select;
    logic [3:0]  we;
    logic        rd;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        output select, we, rd, addr, wdata,
        input  rdata
    );

    modport slave (
        input  select, we, rd, addr, wdata,
        output rdata
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: per-source enable and level/edge mode, sticky edge
// pending bits with write-1-to-clear ACK, and a priority-encoded CAUSE
// register (bit 0 highest priority). Drives a registered irq to the CPU.
module irq_controller #(
    parameter int unsigned NUM_SRC = 5
) (
    input  logic               clk,
    input  logic               resetq,
    input  logic [NUM_SRC-1:0] src,
    irq_controller_if.slave    bus,
    output logic               irq
);

    logic [NUM_SRC-1:0] src_q, src_d;
    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] enable_q, enable_d;
    logic [NUM_SRC-1:0] mode_q, mode_d;
    logic               irq_q, irq_d;

    logic [31:0]        wmask;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] active;
    logic [NUM_SRC-1:0] masked;
    logic               cause_valid;
    logic [4:0]         cause_idx;

    // Read strobe carries no side effects; upper write bits are not stored.
    logic unused_bus;
    assign unused_bus = ^{bus.rd, bus.wdata, wmask};

    // Expand byte strobes to a bit mask and decode ENABLE/MODE/ACK writes.
    always_comb begin
        wmask    = {{8{bus.we[3]}}, {8{bus.we[2]}}, {8{bus.we[1]}}, {8{bus.we[0]}}};
        enable_d = enable_q;
        mode_d   = mode_q;
        ack_clr  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.select && wmask[i]) begin
                case (bus.addr)
                    2'd1:    enable_d[i] = bus.wdata[i];
                    2'd2:    mode_d[i]   = bus.wdata[i];
                    2'd3:    ack_clr[i]  = bus.wdata[i];
                    default: ;
                endcase
            end
        end
    end

    // Source path: edge capture with set-over-clear, level/edge selection
    // and the request that gets registered onto irq.
    always_comb begin
        src_d = src;
        rise  = src & ~src_q;
        // Masking with the next MODE value clears pending on the same edge
        // that switches a source to level mode.
        pending_d = ((pending_q & ~ack_clr) | rise) & mode_d;
        active    = (pending_q & mode_q) | (src_q & ~mode_q);
        masked    = active & enable_q;
        irq_d     = |masked;
    end

    // Lowest-numbered enabled active source wins.
    always_comb begin
        cause_valid = |masked;
        cause_idx   = '0;
        for (int unsigned i = NUM_SRC; i > 0; i--) begin
            if (masked[i-1]) begin
                cause_idx = 5'(i - 1);
            end
        end
    end

    // Combinational register read mux.
    always_comb begin
        bus.rdata = '0;
        case (bus.addr)
            2'd0: begin
                bus.rdata     = 32'(masked);
                bus.rdata[31] = irq_q;
            end
            2'd1:    bus.rdata = 32'(enable_q);
            2'd2:    bus.rdata = 32'(mode_q);
            default: bus.rdata = cause_valid ? {1'b1, 26'b0, cause_idx} : '0;
        endcase
    end

    // State registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            src_q     <= '0;
            pending_q <= '0;
            enable_q  <= '0;
            mode_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            src_q     <= src_d;
            pending_q <= pending_d;
            enable_q  <= enable_d;
            mode_q    <= mode_d;
            irq_q     <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule
